// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC command-stream front end:
//   - 4-bit command codes (cmd_data[7:4] of an ALE=1 byte)
//   - error code enumeration reported with err_pulse
//   - parser FSM state encoding
//   - addr_len_bytes(): maps the 3-bit address code to a byte count
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam logic [3:0] OP_IDLE    = 4'b1000;
  localparam logic [3:0] OP_READ    = 4'b1001;
  localparam logic [3:0] OP_RD_RESP = 4'b1010;
  localparam logic [3:0] OP_WRITE   = 4'b1011;
  localparam logic [3:0] OP_WR_RESP = 4'b1100;
  localparam logic [3:0] OP_RSVD    = 4'b1101;
  localparam logic [3:0] OP_MSG     = 4'b1110;
  localparam logic [3:0] OP_END     = 4'b1111;

  typedef enum logic [1:0] {
    ERR_TRUNC  = 2'd0,
    ERR_FORMAT = 2'd1,
    ERR_UNSUP  = 2'd2
  } err_code_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRC,
    S_ADDR,
    S_DATA,
    S_LEN,
    S_SKIP
  } state_t;

  function automatic logic [3:0] addr_len_bytes(input logic [2:0] acode);
    logic [3:0] n;
    case (acode)
      3'd0:    n = 4'd1;
      3'd1:    n = 4'd2;
      3'd2:    n = 4'd3;
      3'd3:    n = 4'd4;
      3'd4:    n = 4'd5;
      3'd5:    n = 4'd7;
      3'd6:    n = 4'd8;
      default: n = 4'd12;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/noc_pkt_out_reg.sv
// -----------------------------------------------------------------------------
// noc_pkt_out_reg
// Single-entry valid/ready holding register. A packet offered with i_load is
// taken when the register is empty or is being popped in the same cycle;
// otherwise it is dropped and the saturating drop counter advances.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_load, i_data  completed packet offer (one-cycle strobe + payload)
//   i_ready         consumer pop enable (pop = o_valid && i_ready)
//   o_valid, o_data held packet
//   o_drop_cnt      saturating count of dropped packets
// -----------------------------------------------------------------------------
module noc_pkt_out_reg #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [W-1:0]     i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [W-1:0]     o_data,
  output logic [CNT_W-1:0] o_drop_cnt
);

  logic             r_valid;
  logic [W-1:0]     r_data;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             w_pop;
  logic             w_take;

  assign w_pop  = r_valid & i_ready;
  assign w_take = i_load & (~r_valid | w_pop);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      // NOTE: the payload is reset as well so the bus reads all-zero in reset.
      r_data     <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_take) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
      if (i_load && !w_take && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/noc_cmd_parser.sv
// -----------------------------------------------------------------------------
// noc_cmd_parser
// Parses the {ALE, byte} command stream into READ/WRITE request packets and
// presents each on a single-entry valid/ready output register.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   cmd_ale, cmd_data    stream input, one byte per clock (ALE=1: command)
//   pkt_valid/pkt_ready  output handshake
//   pkt_is_write, pkt_src_id, pkt_addr, pkt_addr_bytes, pkt_data, pkt_len
//                        decoded fields of the held packet
//   err_pulse, err_code  one-cycle error strobe and its code
//   drop_cnt, err_cnt    saturating drop / error counters
// -----------------------------------------------------------------------------
module noc_cmd_parser
  import noc_pkg::*;
#(
  parameter int DATA_BYTES     = 4,
  parameter int MAX_ADDR_BYTES = 12,
  parameter int CNT_W          = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_ale,
  input  logic [7:0]                  cmd_data,
  output logic                        pkt_valid,
  input  logic                        pkt_ready,
  output logic                        pkt_is_write,
  output logic [7:0]                  pkt_src_id,
  output logic [MAX_ADDR_BYTES*8-1:0] pkt_addr,
  output logic [3:0]                  pkt_addr_bytes,
  output logic [DATA_BYTES*8-1:0]     pkt_data,
  output logic [15:0]                 pkt_len,
  output logic                        err_pulse,
  output logic [1:0]                  err_code,
  output logic [CNT_W-1:0]            drop_cnt,
  output logic [CNT_W-1:0]            err_cnt
);

  localparam int AW   = MAX_ADDR_BYTES * 8;
  localparam int DW   = DATA_BYTES * 8;
  localparam int PW   = 1 + 8 + AW + 4 + DW + 16;
  localparam int BC_W = $clog2((DATA_BYTES > 16) ? DATA_BYTES : 16);

  state_t           r_state;
  state_t           w_next;
  logic             r_is_write;
  logic             r_len2;
  logic [3:0]       r_n;
  logic [7:0]       r_src;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_data;
  logic [7:0]       r_len_hi;
  logic [BC_W-1:0]  r_cnt;
  logic             r_err_pulse;
  err_code_t        r_err_code;
  logic [CNT_W-1:0] r_err_cnt;

  logic [3:0]       w_code;
  logic [3:0]       w_n;
  logic             w_is_rw;
  logic             w_is_nop;
  logic             w_fmt_ok;
  logic             w_accept;
  logic             w_in_pkt;
  logic             w_addr_last;
  logic             w_data_last;
  logic             w_len_last;
  logic             w_done;
  logic             w_err;
  err_code_t        w_err_code;
  logic [PW-1:0]    w_pkt_in;
  logic [PW-1:0]    w_pkt_out;

  // ---------------------------------------------------------------------------
  // Command byte decode. cmd_data[4] doubles as the code LSB and the len2 flag,
  // so READ (1001) and WRITE (1011) always carry a 2-byte length field.
  // ---------------------------------------------------------------------------
  assign w_code   = cmd_data[7:4];
  assign w_n      = addr_len_bytes(cmd_data[2:0]);
  assign w_fmt_ok = cmd_data[3] && (int'(w_n) <= MAX_ADDR_BYTES);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch.
  always_comb begin
    w_is_rw  = 1'b0;
    w_is_nop = 1'b0;
    case (w_code)
      OP_READ, OP_WRITE:                        w_is_rw  = 1'b1;
      OP_IDLE, OP_END:                          w_is_nop = 1'b1;
      OP_RD_RESP, OP_WR_RESP, OP_RSVD, OP_MSG:  w_is_rw  = 1'b0;
      default:                                  w_is_rw  = 1'b0;
    endcase
  end

  assign w_accept    = cmd_ale && w_is_rw && w_fmt_ok;
  assign w_in_pkt    = r_state inside {S_SRC, S_ADDR, S_DATA, S_LEN};
  assign w_addr_last = (int'(r_cnt) == int'(r_n) - 1);
  assign w_data_last = (int'(r_cnt) == DATA_BYTES - 1);
  assign w_len_last  = (int'(r_cnt) == (r_len2 ? 1 : 0));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. An ALE=1 byte is always decoded as a new command, whatever
  // the current state, so back-to-back packets lose no bytes.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    if (cmd_ale) begin
      if (w_is_rw)       w_next = w_fmt_ok ? S_SRC : S_SKIP;
      else if (w_is_nop) w_next = S_IDLE;
      else               w_next = S_SKIP;
    end else begin
      case (r_state)
        S_SRC:   w_next = S_ADDR;
        S_ADDR:  if (w_addr_last) w_next = r_is_write ? S_DATA : S_LEN;
        S_DATA:  if (w_data_last) w_next = S_LEN;
        S_LEN:   if (w_len_last)  w_next = S_IDLE;
        default: w_next = r_state;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Truncation takes priority when an aborting command byte is
  // itself malformed, so a single byte never reports two events.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_err      = 1'b0;
    w_err_code = ERR_TRUNC;
    w_done     = 1'b0;
    if (cmd_ale) begin
      if (w_in_pkt) begin
        w_err      = 1'b1;
        w_err_code = ERR_TRUNC;
      end else if (w_is_rw && !w_fmt_ok) begin
        w_err      = 1'b1;
        w_err_code = ERR_FORMAT;
      end else if (!w_is_rw && !w_is_nop) begin
        w_err      = 1'b1;
        w_err_code = ERR_UNSUP;
      end
    end else if (r_state == S_LEN && w_len_last) begin
      w_done = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Field datapath. Shift registers are cleared on every accepted command, so
  // short addresses come out right-aligned and READ data stays zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_write <= 1'b0;
      r_len2     <= 1'b0;
      r_n        <= '0;
      r_src      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_len_hi   <= '0;
      r_cnt      <= '0;
    end else if (cmd_ale) begin
      if (w_accept) begin
        r_is_write <= (w_code == OP_WRITE);
        r_len2     <= cmd_data[4];
        r_n        <= w_n;
        r_src      <= '0;
        r_addr     <= '0;
        r_data     <= '0;
        r_len_hi   <= '0;
        r_cnt      <= '0;
      end
    end else begin
      case (r_state)
        S_SRC: begin
          r_src <= cmd_data;
          r_cnt <= '0;
        end
        S_ADDR: begin
          r_addr <= (r_addr << 8) | AW'(cmd_data);
          r_cnt  <= w_addr_last ? '0 : r_cnt + BC_W'(1);
        end
        S_DATA: begin
          r_data <= (r_data << 8) | DW'(cmd_data);
          r_cnt  <= w_data_last ? '0 : r_cnt + BC_W'(1);
        end
        S_LEN: begin
          r_len_hi <= cmd_data;
          r_cnt    <= r_cnt + BC_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Error strobe and saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_pulse <= 1'b0;
      r_err_code  <= ERR_TRUNC;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_err;
      r_err_code  <= w_err ? w_err_code : ERR_TRUNC;
      if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  // The final LEN byte is taken straight from the input; with a 1-byte length
  // r_len_hi is still zero, which gives the zero extension.
  assign w_pkt_in = {r_is_write, r_src, r_addr, r_n, r_data, r_len_hi, cmd_data};

  noc_pkt_out_reg #(
    .W     (PW),
    .CNT_W (CNT_W)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_done),
    .i_data     (w_pkt_in),
    .i_ready    (pkt_ready),
    .o_valid    (pkt_valid),
    .o_data     (w_pkt_out),
    .o_drop_cnt (drop_cnt)
  );

  assign {pkt_is_write, pkt_src_id, pkt_addr, pkt_addr_bytes, pkt_data, pkt_len} = w_pkt_out;

  assign err_pulse = r_err_pulse;
  assign err_code  = r_err_code;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_noc_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_noc_cmd_parser
// Self-checking bench for noc_cmd_parser: directed sequences with constant
// expectations, a per-cycle vector table, and randomized packet streams
// compared against a byte-collecting reference model.
// -----------------------------------------------------------------------------
module tb_noc_cmd_parser;

  localparam int DATA_BYTES     = 4;
  localparam int MAX_ADDR_BYTES = 12;
  localparam int CNT_W          = 8;
  localparam int AW             = MAX_ADDR_BYTES * 8;
  localparam int DW             = DATA_BYTES * 8;
  localparam int CNT_MAX        = (1 << CNT_W) - 1;
  localparam int ALEN[8]        = '{1, 2, 3, 4, 5, 7, 8, 12};

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_ale;
  logic [7:0]          cmd_data;
  logic                pkt_valid;
  logic                pkt_ready;
  logic                pkt_is_write;
  logic [7:0]          pkt_src_id;
  logic [AW-1:0]       pkt_addr;
  logic [3:0]          pkt_addr_bytes;
  logic [DW-1:0]       pkt_data;
  logic [15:0]         pkt_len;
  logic                err_pulse;
  logic [1:0]          err_code;
  logic [CNT_W-1:0]    drop_cnt;
  logic [CNT_W-1:0]    err_cnt;

  always #5 clk = ~clk;

  noc_cmd_parser #(
    .DATA_BYTES     (DATA_BYTES),
    .MAX_ADDR_BYTES (MAX_ADDR_BYTES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_ale        (cmd_ale),
    .cmd_data       (cmd_data),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .pkt_is_write   (pkt_is_write),
    .pkt_src_id     (pkt_src_id),
    .pkt_addr       (pkt_addr),
    .pkt_addr_bytes (pkt_addr_bytes),
    .pkt_data       (pkt_data),
    .pkt_len        (pkt_len),
    .err_pulse      (err_pulse),
    .err_code       (err_code),
    .drop_cnt       (drop_cnt),
    .err_cnt        (err_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: collects the field bytes of an accepted command into a
  // queue and slices them into fields once the expected count is reached.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic          is_write;
    logic [7:0]    src;
    logic [AW-1:0] addr;
    logic [3:0]    abytes;
    logic [DW-1:0] data;
    logic [15:0]   len;
  } pkt_t;

  bit         m_active;
  bit         m_is_write;
  int         m_n;
  int         m_need;
  logic [7:0] m_q[$];
  bit         m_valid;
  pkt_t       m_pkt;
  bit         m_err;
  logic [1:0] m_code;
  int         m_drop;
  int         m_errc;

  task automatic model_reset();
    m_active = 0; m_is_write = 0; m_n = 0; m_need = 0; m_q.delete();
    m_valid = 0; m_pkt = '0; m_err = 0; m_code = 0; m_drop = 0; m_errc = 0;
  endtask

  task automatic model_step(input logic ale, input logic [7:0] d, input logic rdy);
    bit pop, done, err;
    logic [1:0] code;
    pkt_t np;
    int idx, c4;
    pop = m_valid && rdy;
    done = 0; err = 0; code = 0; np = '0;
    if (ale) begin
      c4 = int'(d[7:4]);
      if (m_active) begin err = 1; code = 2'd0; end
      m_active = 0;
      if (c4 == 9 || c4 == 11) begin
        if (d[3] && ALEN[d[2:0]] <= MAX_ADDR_BYTES) begin
          m_active   = 1;
          m_is_write = (c4 == 11);
          m_n        = ALEN[d[2:0]];
          m_need     = 1 + m_n + (m_is_write ? DATA_BYTES : 0) + (d[4] ? 2 : 1);
          m_q.delete();
        end else if (!err) begin
          err = 1; code = 2'd1;
        end
      end else if (c4 != 8 && c4 != 15) begin
        if (!err) begin err = 1; code = 2'd2; end
      end
    end else if (m_active) begin
      m_q.push_back(d);
      if (m_q.size() == m_need) begin
        done = 1;
        m_active = 0;
        np.is_write = m_is_write;
        np.src = m_q[0];
        np.abytes = 4'(m_n);
        idx = 1;
        for (int i = 0; i < m_n; i++) begin np.addr = {np.addr[AW-9:0], m_q[idx]}; idx++; end
        if (m_is_write)
          for (int i = 0; i < DATA_BYTES; i++) begin np.data = {np.data[DW-9:0], m_q[idx]}; idx++; end
        while (idx < m_need) begin np.len = {np.len[7:0], m_q[idx]}; idx++; end
      end
    end
    if (done) begin
      if (!m_valid || pop) begin m_pkt = np; m_valid = 1; end
      else if (m_drop < CNT_MAX) m_drop++;
    end else if (pop) begin
      m_valid = 0;
    end
    m_err  = err;
    m_code = err ? code : 2'd0;
    if (err && m_errc < CNT_MAX) m_errc++;
  endtask

  task automatic compare();
    check("pkt_valid", pkt_valid, m_valid);
    if (m_valid) begin
      check("pkt_is_write", pkt_is_write, m_pkt.is_write);
      check("pkt_src_id", pkt_src_id, m_pkt.src);
      check("pkt_addr", pkt_addr, m_pkt.addr);
      check("pkt_addr_bytes", pkt_addr_bytes, m_pkt.abytes);
      check("pkt_data", pkt_data, m_pkt.data);
      check("pkt_len", pkt_len, m_pkt.len);
    end
    check("err_pulse", err_pulse, m_err);
    if (m_err) check("err_code", err_code, m_code);
    check("drop_cnt", drop_cnt, m_drop);
    check("err_cnt", err_cnt, m_errc);
  endtask

  // One stream byte: drive away from the edge, step the model, sample 1 after.
  task automatic cycle(input logic ale, input logic [7:0] d, input logic rdy);
    cmd_ale = ale; cmd_data = d; pkt_ready = rdy;
    model_step(ale, d, rdy);
    @(posedge clk);
    #1;
    compare();
  endtask

  // First byte is the command (ALE=1); ready can differ on the last byte.
  task automatic send_pkt(input logic [7:0] b[$], input logic rdy, input logic rdy_last);
    for (int i = 0; i < b.size(); i++)
      cycle((i == 0), b[i], (i == b.size() - 1) ? rdy_last : rdy);
  endtask

  task automatic check_pkt(input string tag, input logic w, input logic [7:0] src,
                           input logic [AW-1:0] addr, input logic [3:0] ab,
                           input logic [DW-1:0] data, input logic [15:0] len);
    check({tag, "_valid"}, pkt_valid, 1'b1);
    check({tag, "_is_write"}, pkt_is_write, w);
    check({tag, "_src"}, pkt_src_id, src);
    check({tag, "_addr"}, pkt_addr, addr);
    check({tag, "_addr_bytes"}, pkt_addr_bytes, ab);
    check({tag, "_data"}, pkt_data, data);
    check({tag, "_len"}, pkt_len, len);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, pkt_valid, 0);
    check({tag, "_is_write"}, pkt_is_write, 0);
    check({tag, "_src"}, pkt_src_id, 0);
    check({tag, "_addr"}, pkt_addr, 0);
    check({tag, "_addr_bytes"}, pkt_addr_bytes, 0);
    check({tag, "_data"}, pkt_data, 0);
    check({tag, "_len"}, pkt_len, 0);
    check({tag, "_err_pulse"}, err_pulse, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  // Per-cycle vector table.
  typedef struct packed {
    logic       ale;
    logic [7:0] data;
    logic       rdy;
    logic       exp_valid;
    logic       exp_err;
    logic [1:0] exp_code;
    logic [7:0] exp_err_cnt;
  } vec_t;

  function automatic vec_t mk(input logic ale, input logic [7:0] d, input logic v,
                              input logic e, input logic [1:0] c, input logic [7:0] ec);
    vec_t r;
    r.ale = ale; r.data = d; r.rdy = 1'b1; r.exp_valid = v;
    r.exp_err = e; r.exp_code = c; r.exp_err_cnt = ec;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    vec_t       vtab[$];
    logic [7:0] q[$];
    logic [7:0] cmd;
    int         kind, full, nb;
    logic [2:0] ac;

    // Format/unsupported then truncation, ready held high throughout.
    vtab.push_back(mk(1, 8'h93, 0, 1, 2'd1, 8'd1));
    vtab.push_back(mk(0, 8'hAA, 0, 0, 2'd0, 8'd1));
    vtab.push_back(mk(0, 8'hBB, 0, 0, 2'd0, 8'd1));
    vtab.push_back(mk(1, 8'hD8, 0, 1, 2'd2, 8'd2));
    vtab.push_back(mk(0, 8'hCC, 0, 0, 2'd0, 8'd2));
    vtab.push_back(mk(0, 8'hDD, 0, 0, 2'd0, 8'd2));
    vtab.push_back(mk(1, 8'hF0, 0, 0, 2'd0, 8'd2));
    vtab.push_back(mk(1, 8'h9B, 0, 0, 2'd0, 8'd2));
    vtab.push_back(mk(0, 8'h05, 0, 0, 2'd0, 8'd2));
    vtab.push_back(mk(0, 8'h11, 0, 0, 2'd0, 8'd2));
    vtab.push_back(mk(1, 8'h9B, 0, 1, 2'd0, 8'd3));
    vtab.push_back(mk(0, 8'h05, 0, 0, 2'd0, 8'd3));
    vtab.push_back(mk(0, 8'h11, 0, 0, 2'd0, 8'd3));
    vtab.push_back(mk(0, 8'h22, 0, 0, 2'd0, 8'd3));
    vtab.push_back(mk(0, 8'h33, 0, 0, 2'd0, 8'd3));
    vtab.push_back(mk(0, 8'h44, 0, 0, 2'd0, 8'd3));
    vtab.push_back(mk(0, 8'h00, 0, 0, 2'd0, 8'd3));
    vtab.push_back(mk(0, 8'h10, 1, 0, 2'd0, 8'd3));
    vtab.push_back(mk(1, 8'h80, 0, 0, 2'd0, 8'd3));

    cmd_ale = 0; cmd_data = 0; pkt_ready = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 0;

    // READ, 4-byte address; bit 4 of 0x9B selects a 2-byte length.
    q = {8'h9B, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h10};
    send_pkt(q, 1'b1, 1'b1);
    check_pkt("read", 1'b0, 8'h05, 96'h1122_3344, 4'd4, 32'h0, 16'h0010);
    cycle(1, 8'h80, 1);
    check("read_popped", pkt_valid, 1'b0);

    // WRITE, 2-byte address, 2-byte length.
    q = {8'hB9, 8'h07, 8'hAB, 8'hCD, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h00};
    send_pkt(q, 1'b1, 1'b1);
    check_pkt("write", 1'b1, 8'h07, 96'hABCD, 4'd2, 32'hDEAD_BEEF, 16'h0100);
    check("write_no_err", err_cnt, 0);
    cycle(1, 8'h80, 1);

    foreach (vtab[i]) begin
      cycle(vtab[i].ale, vtab[i].data, vtab[i].rdy);
      check("tab_valid", pkt_valid, vtab[i].exp_valid);
      check("tab_err_pulse", err_pulse, vtab[i].exp_err);
      if (vtab[i].exp_err) check("tab_err_code", err_code, vtab[i].exp_code);
      check("tab_err_cnt", err_cnt, vtab[i].exp_err_cnt);
    end

    // Backpressure: second packet dropped, first held unchanged.
    q = {8'h9B, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h10};
    send_pkt(q, 1'b0, 1'b0);
    q = {8'h9B, 8'h06, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h20};
    send_pkt(q, 1'b0, 1'b0);
    check("drop_cnt_one", drop_cnt, 1);
    check_pkt("held", 1'b0, 8'h05, 96'h1122_3344, 4'd4, 32'h0, 16'h0010);
    // Pop and completion in the same cycle: new packet loads, valid stays high.
    q = {8'h9B, 8'h09, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'h30};
    send_pkt(q, 1'b0, 1'b1);
    check_pkt("pop_load", 1'b0, 8'h09, 96'hA1A2_A3A4, 4'd4, 32'h0, 16'h0030);
    check("pop_load_drop", drop_cnt, 1);
    cycle(1, 8'h80, 1);
    check("popped", pkt_valid, 1'b0);

    // Reset in the middle of a WRITE address.
    cycle(1, 8'hB9, 1);
    cycle(0, 8'h07, 1);
    cycle(0, 8'hAB, 1);
    #3 rst = 1;
    #1 check_all_zero("mid_reset");
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    q = {8'h9B, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h10};
    send_pkt(q, 1'b1, 1'b1);
    check_pkt("after_reset", 1'b0, 8'h05, 96'h1122_3344, 4'd4, 32'h0, 16'h0010);
    check("after_reset_err_cnt", err_cnt, 0);

    // Randomized packet streams against the model.
    for (int p = 0; p < 500; p++) begin
      kind = $urandom_range(0, 9);
      ac = 3'($urandom_range(0, 7));
      case (kind)
        0, 1, 2, 3: cmd = {4'h9, 1'b1, ac};
        4, 5, 6:    cmd = {4'hB, 1'b1, ac};
        7:          cmd = {($urandom_range(0, 1) != 0) ? 4'h9 : 4'hB, 1'b0, ac};
        8:          cmd = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'hF0;
        default:    cmd = 8'($urandom);
      endcase
      if (kind <= 6) full = 1 + ALEN[ac] + ((kind >= 4) ? DATA_BYTES : 0) + 2;
      else           full = $urandom_range(0, 3);
      nb = ($urandom_range(0, 9) == 0) ? $urandom_range(0, full) : full;
      cycle(1, cmd, ($urandom_range(0, 3) != 0));
      for (int i = 0; i < nb; i++) cycle(0, 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
